apb_to_ahb_bridge: RTL and testbench
====================================

// Module: apb_to_ahb_bridge
// PURPOSE
//  APB4 completer to AHB-lite manager bridge: the reverse direction of the AHB-to-APB bridge.
//  Lets an APB-side requester (debug/config port) issue single AHB-lite transfers.
//  Sits between an APB fabric and one AHB-lite manager port. Single clock domain: PCLK is HCLK.
//  One outstanding transfer. No bursts, no pipelining of back-to-back APB accesses.
// PARAMETERS
//  ADDR_W      32  address width; PADDR and HADDR share this width.
//  STRB_ERR    1   1: illegal write PSTRB gives PSLVERR with no AHB transfer. 0: treated as a word write.
// PORTS
//  HCLK       in   1       clock for both APB and AHB sides.
//  HRESETn    in   1       reset; synchronous, active-low.
//  PSEL       in   1       APB select.
//  PENABLE    in   1       APB access phase.
//  PWRITE     in   1       APB direction.
//  PADDR      in   ADDR_W  APB address; bits [1:0] are ignored.
//  PWDATA     in   32      APB write data.
//  PSTRB      in   4       APB write strobes.
//  PPROT      in   3       APB protection.
//  PRDATA     out  32      read data; valid while PREADY=1.
//  PREADY     out  1       transfer complete.
//  PSLVERR    out  1       error; valid while PREADY=1.
//  HADDR      out  ADDR_W  AHB address.
//  HTRANS     out  2       IDLE (2'b00) or NONSEQ (2'b10) only.
//  HWRITE     out  1       AHB direction.
//  HSIZE      out  3       byte (000), half (001) or word (010).
//  HBURST     out  3       constant SINGLE (000).
//  HPROT      out  4       {2'b00, PPROT[0], ~PPROT[2]}, latched at setup.
//  HMASTLOCK  out  1       constant 0.
//  HWDATA     out  32      AHB write data.
//  HRDATA     in   32      AHB read data.
//  HREADY     in   1       AHB ready.
//  HRESP      in   1       AHB response: 0 OKAY, 1 ERROR.
// BEHAVIOUR
//  Reset (HRESETn=0 at a HCLK edge) sets:
//   - state=ST_IDLE, HTRANS=IDLE, HADDR=0, HWRITE=0, HSIZE=010, HWDATA=0, HPROT=0011.
//   - PREADY=0, PSLVERR=0, PRDATA=0.
//  All AHB outputs are driven from registers; there is no combinational APB-to-AHB path.
//  State machine:
//   ST_IDLE: on PSEL & !PENABLE (setup), latch PADDR, PWRITE, PWDATA, PSTRB, PPROT.
//            Legal request -> ST_ADDR. Illegal write strobe with STRB_ERR=1 -> ST_RESP, err=1.
//   ST_ADDR: HTRANS=NONSEQ; HADDR, HWRITE, HSIZE from latches. HREADY=1 -> ST_DATA; else hold.
//   ST_DATA: HTRANS=IDLE; HWDATA=latched wdata.
//            HREADY=1 -> capture HRDATA into rdata and HRESP into err, then -> ST_RESP.
//            HRESP=1 & HREADY=0 (first error cycle) -> stay in ST_DATA.
//   ST_RESP: PREADY=1, PRDATA=rdata, PSLVERR=err, for exactly one cycle -> ST_IDLE.
//  Latency with zero-wait AHB: setup at T0, NONSEQ at T1, data phase at T2, PREADY=1 at T3.
//  Each AHB wait state adds one cycle.
//  Reads: HSIZE=word, HADDR[1:0]=00; PSTRB is ignored.
//  Writes: PSTRB decodes to (HSIZE, HADDR[1:0]):
//   - 1111 -> word, 00.
//   - 0011 -> half, 00.    1100 -> half, 10.
//   - 0001 -> byte, 00.    0010 -> byte, 01.    0100 -> byte, 10.    1000 -> byte, 11.
//   - Any other value (including 0000) is illegal.
//  PRDATA is held at the last captured value outside ST_RESP. PSLVERR is 0 outside ST_RESP.
//  PENABLE without PSEL is ignored. A new setup while busy is ignored (APB protocol excludes it).
//  PSEL deasserted mid-transfer: the AHB transfer still completes and PREADY still pulses.
//  Reset mid-transfer: ST_IDLE and HTRANS=IDLE on the next edge; the in-flight AHB data phase is abandoned.
// STRUCTURE
//  Shared package ahb_apb_pkg holds:
//   - HTRANS_IDLE/NONSEQ, HSIZE_BYTE/HALF/WORD and HBURST_SINGLE constants.
//   - The bridge state encoding (ST_IDLE, ST_ADDR, ST_DATA, ST_RESP).
//  Sub-module apb_strb_decoder: combinational map PSTRB -> {hsize[2:0], addr_lo[1:0], legal}.
//  Everything else is in this module.
// TESTING
//  - Read, PADDR=0x4000_0010, HREADY=1, HRDATA=0xDEAD_BEEF
//      -> NONSEQ at T1 with HADDR=0x4000_0010, HSIZE=010; PREADY=1 at T3 with PRDATA=0xDEAD_BEEF.
//  - Write, PADDR=0x100, PSTRB=0100, PWDATA=0x00AB_0000
//      -> HADDR=0x102, HSIZE=000, HWRITE=1; HWDATA=0x00AB_0000 in the data phase.
//  - Read with HREADY low for 3 data-phase cycles -> PREADY rises at T6 and stays high one cycle only.
//  - Write with HRESP=1 for 2 cycles (HREADY 0 then 1) -> PSLVERR=1 with PREADY; ST_IDLE next.
//  - Write, PSTRB=0101, STRB_ERR=1 -> no NONSEQ ever; PREADY=1 and PSLVERR=1 at T1.
//  - HRESETn=0 during ST_DATA -> HTRANS=IDLE and PREADY=0 next edge; a following read completes normally.

Source files
------------

// File: rtl/ahb_apb_pkg.sv
// Shared AHB-lite/APB encodings and the APB-to-AHB bridge state and strobe-decode types.
// Pure definitions: no logic and no latency.
package ahb_apb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE    = 3'b000;
  localparam logic [2:0] HSIZE_HALF    = 3'b001;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic [3:0] HPROT_RST     = 4'b0011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_DATA = 2'b10,
    ST_RESP = 2'b11
  } bridge_state_t;

  typedef struct packed {
    logic [2:0] hsize;
    logic [1:0] addr_lo;
    logic       legal;
  } strb_dec_t;

  // APB privileged -> AHB privileged, APB instruction -> AHB opcode fetch (inverted sense).
  function automatic logic [3:0] hprot_map(input logic [2:0] pprot);
    return {2'b00, pprot[0], ~pprot[2]};
  endfunction

endpackage

// File: rtl/apb_strb_decoder.sv
// Combinational PSTRB -> {hsize, addr_lo, legal}; only naturally aligned byte/half/word
// patterns are legal. Zero latency, no flow control.
module apb_strb_decoder
  import ahb_apb_pkg::*;
(
  input  logic [3:0] pstrb,
  output strb_dec_t  dec
);

  always_comb begin
    dec = '{hsize: HSIZE_WORD, addr_lo: 2'b00, legal: 1'b0};
    case (pstrb)
      4'b1111: dec = '{hsize: HSIZE_WORD, addr_lo: 2'b00, legal: 1'b1};
      4'b0011: dec = '{hsize: HSIZE_HALF, addr_lo: 2'b00, legal: 1'b1};
      4'b1100: dec = '{hsize: HSIZE_HALF, addr_lo: 2'b10, legal: 1'b1};
      4'b0001: dec = '{hsize: HSIZE_BYTE, addr_lo: 2'b00, legal: 1'b1};
      4'b0010: dec = '{hsize: HSIZE_BYTE, addr_lo: 2'b01, legal: 1'b1};
      4'b0100: dec = '{hsize: HSIZE_BYTE, addr_lo: 2'b10, legal: 1'b1};
      4'b1000: dec = '{hsize: HSIZE_BYTE, addr_lo: 2'b11, legal: 1'b1};
      default: dec = '{hsize: HSIZE_WORD, addr_lo: 2'b00, legal: 1'b0};
    endcase
  end

endmodule

// File: rtl/apb_to_ahb_bridge.sv
// APB4 completer issuing single AHB-lite transfers; PREADY three cycles after setup with a
// zero-wait AHB, each HREADY-low cycle stretches the APB access by one cycle.
module apb_to_ahb_bridge
  import ahb_apb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter bit STRB_ERR = 1'b1
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [31:0]       PWDATA,
  input  logic [3:0]        PSTRB,
  input  logic [2:0]        PPROT,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic [3:0]        HPROT,
  output logic              HMASTLOCK,
  output logic [31:0]       HWDATA,
  input  logic [31:0]       HRDATA,
  input  logic              HREADY,
  input  logic              HRESP
);

  bridge_state_t state, state_nxt;
  strb_dec_t     dec;

  logic              setup_vld;
  logic              strb_bad;
  logic              setup_ld;
  logic              data_cap;
  logic [2:0]        req_hsize;
  logic [1:0]        req_addr_lo;

  logic [ADDR_W-1:0] haddr_q;
  logic              hwrite_q;
  logic [2:0]        hsize_q;
  logic [31:0]       hwdata_q;
  logic [3:0]        hprot_q;
  logic [31:0]       rdata_q;
  logic              err_q;

  logic              unused_addr_lo;
  assign unused_addr_lo = ^PADDR[1:0];

  apb_strb_decoder u_strb_dec (
    .pstrb (PSTRB),
    .dec   (dec)
  );

  assign setup_vld = PSEL & ~PENABLE;
  assign strb_bad  = PWRITE & ~dec.legal & STRB_ERR;

  // Reads, and illegal strobes when they are not faulted, go out as aligned word accesses.
  always_comb begin
    req_hsize   = HSIZE_WORD;
    req_addr_lo = 2'b00;
    if (PWRITE && dec.legal) begin
      req_hsize   = dec.hsize;
      req_addr_lo = dec.addr_lo;
    end
  end

  always_comb begin
    state_nxt = state;
    setup_ld  = 1'b0;
    data_cap  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (setup_vld) begin
          setup_ld  = 1'b1;
          state_nxt = strb_bad ? ST_RESP : ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (HREADY) state_nxt = ST_DATA;
      end
      ST_DATA: begin
        if (HREADY) begin
          data_cap  = 1'b1;
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      haddr_q  <= '0;
      hwrite_q <= 1'b0;
      hsize_q  <= HSIZE_WORD;
      hwdata_q <= '0;
      hprot_q  <= HPROT_RST;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else if (setup_ld) begin
      haddr_q  <= {PADDR[ADDR_W-1:2], req_addr_lo};
      hwrite_q <= PWRITE;
      hsize_q  <= req_hsize;
      hwdata_q <= PWDATA;
      hprot_q  <= hprot_map(PPROT);
      err_q    <= strb_bad;
    end else if (data_cap) begin
      rdata_q  <= HRDATA;
      err_q    <= HRESP;
    end
  end

  assign HTRANS    = (state == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HADDR     = haddr_q;
  assign HWRITE    = hwrite_q;
  assign HSIZE     = hsize_q;
  assign HWDATA    = hwdata_q;
  assign HPROT     = hprot_q;
  assign HBURST    = HBURST_SINGLE;
  assign HMASTLOCK = 1'b0;

  assign PREADY    = (state == ST_RESP);
  assign PSLVERR   = PREADY & err_q;
  assign PRDATA    = rdata_q;

endmodule

// File: tb/tb_apb_to_ahb_bridge.sv
// Directed bench for apb_to_ahb_bridge: table of zero-wait transfers plus hand-written
// wait-state, error, reset and PSEL-drop sequences.
module tb_apb_to_ahb_bridge;

  logic        HCLK;
  logic        HRESETn;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA;
  logic [3:0]  PSTRB;
  logic [2:0]  PPROT;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic        HMASTLOCK;
  logic [31:0] HWDATA, HRDATA;
  logic        HREADY, HRESP;

  int ncmp = 0;
  int nerr = 0;

  apb_to_ahb_bridge #(.ADDR_W(32), .STRB_ERR(1'b1)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  typedef struct {
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic [31:0] hrdata;
    logic        ahb;
    logic [31:0] exp_haddr;
    logic [2:0]  exp_hsize;
    logic [3:0]  exp_hprot;
    logic [31:0] exp_prdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [11];

  task automatic tick;
    @(posedge HCLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic apb_setup(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb, input logic [2:0] prot);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr;
    PWDATA = wdata; PSTRB = strb; PPROT = prot;
  endtask

  task automatic apb_release;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  // Zero-wait transfer: setup T0, NONSEQ T1, data T2, PREADY T3 (illegal strobe: PREADY T1).
  task automatic run_vec(input vec_t v, input int idx);
    HREADY = 1'b1; HRESP = 1'b0;
    apb_setup(v.pwrite, v.paddr, v.pwdata, v.pstrb, v.pprot);
    tick;
    PENABLE = 1'b1;
    if (v.ahb) begin
      chk($sformatf("v%0d T1 htrans", idx), {30'd0, HTRANS}, 32'h2);
      chk($sformatf("v%0d T1 haddr", idx), HADDR, v.exp_haddr);
      chk($sformatf("v%0d T1 hsize", idx), {29'd0, HSIZE}, {29'd0, v.exp_hsize});
      chk($sformatf("v%0d T1 hwrite", idx), {31'd0, HWRITE}, {31'd0, v.pwrite});
      chk($sformatf("v%0d T1 hprot", idx), {28'd0, HPROT}, {28'd0, v.exp_hprot});
      chk($sformatf("v%0d T1 pready", idx), {31'd0, PREADY}, 32'd0);
      tick;
      chk($sformatf("v%0d T2 htrans", idx), {30'd0, HTRANS}, 32'h0);
      if (v.pwrite) chk($sformatf("v%0d T2 hwdata", idx), HWDATA, v.pwdata);
      HRDATA = v.hrdata;
      tick;
    end else begin
      chk($sformatf("v%0d T1 htrans", idx), {30'd0, HTRANS}, 32'h0);
    end
    chk($sformatf("v%0d pready", idx), {31'd0, PREADY}, 32'd1);
    chk($sformatf("v%0d pslverr", idx), {31'd0, PSLVERR}, {31'd0, v.exp_err});
    chk($sformatf("v%0d prdata", idx), PRDATA, v.exp_prdata);
    apb_release;
    HRDATA = 32'h0;
    tick;
    chk($sformatf("v%0d post pready", idx), {31'd0, PREADY}, 32'd0);
    chk($sformatf("v%0d post pslverr", idx), {31'd0, PSLVERR}, 32'd0);
    chk($sformatf("v%0d post htrans", idx), {30'd0, HTRANS}, 32'h0);
    chk($sformatf("v%0d post prdata", idx), PRDATA, v.exp_prdata);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 32'h4000_0010, 32'h0,         4'hF, 3'b000, 32'hDEAD_BEEF, 1'b1, 32'h4000_0010, 3'b010, 4'b0001, 32'hDEAD_BEEF, 1'b0};
    vecs[1]  = '{1'b1, 32'h0000_0100, 32'h00AB_0000, 4'h4, 3'b000, 32'h1234_5678, 1'b1, 32'h0000_0102, 3'b000, 4'b0001, 32'h1234_5678, 1'b0};
    vecs[2]  = '{1'b1, 32'h0000_0200, 32'hA5A5_A5A5, 4'hF, 3'b101, 32'h0,         1'b1, 32'h0000_0200, 3'b010, 4'b0010, 32'h0,         1'b0};
    vecs[3]  = '{1'b1, 32'h0000_0303, 32'h0000_BEEF, 4'h3, 3'b001, 32'h1,         1'b1, 32'h0000_0300, 3'b001, 4'b0011, 32'h1,         1'b0};
    vecs[4]  = '{1'b1, 32'h0000_0400, 32'hBEEF_0000, 4'hC, 3'b100, 32'h2,         1'b1, 32'h0000_0402, 3'b001, 4'b0000, 32'h2,         1'b0};
    vecs[5]  = '{1'b1, 32'h0000_0500, 32'h0000_0011, 4'h1, 3'b000, 32'h3,         1'b1, 32'h0000_0500, 3'b000, 4'b0001, 32'h3,         1'b0};
    vecs[6]  = '{1'b1, 32'h0000_0600, 32'h0000_2200, 4'h2, 3'b010, 32'h4,         1'b1, 32'h0000_0601, 3'b000, 4'b0001, 32'h4,         1'b0};
    vecs[7]  = '{1'b1, 32'h0000_0700, 32'h4400_0000, 4'h8, 3'b011, 32'h5,         1'b1, 32'h0000_0703, 3'b000, 4'b0011, 32'h5,         1'b0};
    vecs[8]  = '{1'b0, 32'h8000_0007, 32'h0,         4'h5, 3'b111, 32'hCAFE_F00D, 1'b1, 32'h8000_0004, 3'b010, 4'b0010, 32'hCAFE_F00D, 1'b0};
    vecs[9]  = '{1'b1, 32'h0000_0900, 32'h0000_FFFF, 4'h5, 3'b000, 32'h0,         1'b0, 32'h0,         3'b000, 4'b0000, 32'hCAFE_F00D, 1'b1};
    vecs[10] = '{1'b1, 32'h0000_0A00, 32'h0,         4'h0, 3'b000, 32'h0,         1'b0, 32'h0,         3'b000, 4'b0000, 32'hCAFE_F00D, 1'b1};

    HRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 32'h0;
    PWDATA = 32'h0; PSTRB = 4'h0; PPROT = 3'b000; HRDATA = 32'h0; HREADY = 1'b1; HRESP = 1'b0;
    tick;
    tick;
    chk("rst htrans", {30'd0, HTRANS}, 32'h0);
    chk("rst haddr", HADDR, 32'h0);
    chk("rst hwrite", {31'd0, HWRITE}, 32'd0);
    chk("rst hsize", {29'd0, HSIZE}, 32'h2);
    chk("rst hwdata", HWDATA, 32'h0);
    chk("rst hprot", {28'd0, HPROT}, 32'h3);
    chk("rst hburst", {29'd0, HBURST}, 32'h0);
    chk("rst hmastlock", {31'd0, HMASTLOCK}, 32'd0);
    chk("rst pready", {31'd0, PREADY}, 32'd0);
    chk("rst pslverr", {31'd0, PSLVERR}, 32'd0);
    chk("rst prdata", PRDATA, 32'h0);
    HRESETn = 1'b1;
    tick;

    for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

    // PENABLE without PSEL must not start anything.
    PENABLE = 1'b1;
    tick;
    PENABLE = 1'b0;
    tick;
    chk("penable only htrans", {30'd0, HTRANS}, 32'h0);
    chk("penable only pready", {31'd0, PREADY}, 32'd0);

    // Read with three data-phase wait states: PREADY at T6 for one cycle.
    apb_setup(1'b0, 32'h0000_0010, 32'h0, 4'h0, 3'b000);
    tick;
    PENABLE = 1'b1;
    chk("ws T1 htrans", {30'd0, HTRANS}, 32'h2);
    tick;
    HREADY = 1'b0;
    for (int c = 2; c <= 4; c++) begin
      chk($sformatf("ws T%0d htrans", c), {30'd0, HTRANS}, 32'h0);
      chk($sformatf("ws T%0d pready", c), {31'd0, PREADY}, 32'd0);
      tick;
    end
    HREADY = 1'b1; HRDATA = 32'h1111_2222;
    chk("ws T5 pready", {31'd0, PREADY}, 32'd0);
    tick;
    chk("ws T6 pready", {31'd0, PREADY}, 32'd1);
    chk("ws T6 prdata", PRDATA, 32'h1111_2222);
    apb_release;
    HRDATA = 32'h0;
    tick;
    chk("ws T7 pready", {31'd0, PREADY}, 32'd0);

    // Write with an address-phase wait, then a two-cycle AHB ERROR response.
    apb_setup(1'b1, 32'h0000_0020, 32'h0000_0055, 4'hF, 3'b000);
    HREADY = 1'b0;
    tick;
    PENABLE = 1'b1;
    chk("er T1 htrans", {30'd0, HTRANS}, 32'h2);
    tick;
    chk("er T2 htrans held", {30'd0, HTRANS}, 32'h2);
    chk("er T2 haddr held", HADDR, 32'h0000_0020);
    HREADY = 1'b1;
    tick;
    chk("er T3 htrans", {30'd0, HTRANS}, 32'h0);
    chk("er T3 hwdata", HWDATA, 32'h0000_0055);
    HREADY = 1'b0; HRESP = 1'b1;
    tick;
    chk("er T4 pready", {31'd0, PREADY}, 32'd0);
    HREADY = 1'b1; HRESP = 1'b1; HRDATA = 32'h9999_0000;
    tick;
    chk("er T5 pready", {31'd0, PREADY}, 32'd1);
    chk("er T5 pslverr", {31'd0, PSLVERR}, 32'd1);
    apb_release;
    HRESP = 1'b0; HRDATA = 32'h0;
    tick;
    chk("er T6 pready", {31'd0, PREADY}, 32'd0);
    chk("er T6 pslverr", {31'd0, PSLVERR}, 32'd0);
    chk("er T6 htrans", {30'd0, HTRANS}, 32'h0);

    // Reset during the data phase abandons the transfer.
    apb_setup(1'b0, 32'h0000_0030, 32'h0, 4'h0, 3'b000);
    tick;
    PENABLE = 1'b1;
    tick;
    chk("rd T2 htrans", {30'd0, HTRANS}, 32'h0);
    HREADY = 1'b0; HRESETn = 1'b0;
    tick;
    chk("rd rst htrans", {30'd0, HTRANS}, 32'h0);
    chk("rd rst pready", {31'd0, PREADY}, 32'd0);
    chk("rd rst prdata", PRDATA, 32'h0);
    HRESETn = 1'b1; HREADY = 1'b1;
    apb_release;
    tick;
    chk("rd idle pready", {31'd0, PREADY}, 32'd0);
    run_vec('{1'b0, 32'h0000_0044, 32'h0, 4'h0, 3'b000, 32'h0BAD_F00D, 1'b1,
              32'h0000_0044, 3'b010, 4'b0001, 32'h0BAD_F00D, 1'b0}, 100);

    // PSEL dropped after setup: the AHB transfer and PREADY pulse still happen.
    apb_setup(1'b0, 32'h0000_0050, 32'h0, 4'h0, 3'b000);
    tick;
    apb_release;
    chk("ps T1 htrans", {30'd0, HTRANS}, 32'h2);
    tick;
    HRDATA = 32'h0000_0077;
    tick;
    chk("ps T3 pready", {31'd0, PREADY}, 32'd1);
    chk("ps T3 prdata", PRDATA, 32'h0000_0077);
    HRDATA = 32'h0;
    tick;
    chk("ps T4 pready", {31'd0, PREADY}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
    $finish;
  end

endmodule
